// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter / fetch address generator
//
// Purpose:
//   Holds the fetch PC of a simple in-order core. After reset the unit spends
//   BOOT_CYCLES clocks in BOOT (PC parked at RESET_VECTOR, not valid), then
//   RUNs. Each RUN edge it picks the next PC by priority:
//     trap -> redirect -> stall (hold) -> sequential (pc + STEP).
//   A halt request (debug/single-step) parks the unit in HALT with the PC
//   frozen until halt drops.
//
// Parameters:
//   WIDTH        PC/address width in bits (>= 8)
//   RESET_VECTOR first fetch address after boot
//   BOOT_CYCLES  post-reset clocks before fetch starts (1..15)
//   STEP         sequential increment; assumed to be a power of two
//
// Ports:
//   clk             in   clock, all state on the rising edge
//   rst_n           in   asynchronous active-low reset
//   stall           in   hold PC this cycle
//   halt            in   request halt
//   redirect_valid  in   branch/jump taken
//   redirect_target in   branch/jump destination        [WIDTH]
//   trap_valid      in   trap/exception entry
//   trap_vector     in   trap handler address           [WIDTH]
//   pc              out  current fetch address (registered) [WIDTH]
//   pc_plus_step    out  pc + STEP, modulo 2^WIDTH      [WIDTH]
//   pc_valid        out  pc is a valid fetch address this cycle
//   halted          out  unit is in HALT
//   misalign_err    out  one-cycle pulse, rejected misaligned target
//
// Configuration:
//   PC_MISALIGN_CHECK_EN  when defined, trap/redirect targets that are not a
//                         multiple of STEP are rejected (the next lower
//                         priority action is taken) and misalign_err pulses
//                         the cycle after. When undefined, targets are
//                         accepted with their low log2(STEP) bits cleared and
//                         misalign_err is tied low.
// -----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       BOOT_CYCLES  = 1,
  parameter int unsigned       STEP         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vector,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pc_valid,
  output logic             halted,
  output logic             misalign_err
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // Low address bits that must be zero for an aligned target.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  localparam logic [3:0]       BOOT_LAST  = 4'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       boot_cnt_reg, boot_cnt_next;
  logic [WIDTH-1:0] pc_reg, pc_next;

  // Target qualification: *_ok means the request is taken this edge,
  // *_bad means it was asserted but rejected for alignment.
  logic             trap_ok, trap_bad;
  logic             redir_ok, redir_bad;
  logic [WIDTH-1:0] trap_tgt, redir_tgt;

`ifdef PC_MISALIGN_CHECK_EN
  logic misalign_reg, misalign_next;

  assign trap_bad  = trap_valid     && ((trap_vector     & ALIGN_MASK) != '0);
  assign redir_bad = redirect_valid && ((redirect_target & ALIGN_MASK) != '0);
  assign trap_ok   = trap_valid     && !trap_bad;
  assign redir_ok  = redirect_valid && !redir_bad;
  assign trap_tgt  = trap_vector;
  assign redir_tgt = redirect_target;
`else
  assign trap_bad  = 1'b0;
  assign redir_bad = 1'b0;
  assign trap_ok   = trap_valid;
  assign redir_ok  = redirect_valid;
  // Misaligned targets are silently rounded down to the instruction grid.
  assign trap_tgt  = trap_vector     & ~ALIGN_MASK;
  assign redir_tgt = redirect_target & ~ALIGN_MASK;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_BOOT;
      boot_cnt_reg <= '0;
      pc_reg       <= RESET_VECTOR;
    end else begin
      state_reg    <= state_next;
      boot_cnt_reg <= boot_cnt_next;
      pc_reg       <= pc_next;
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-PC logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    pc_next       = pc_reg;
`ifdef PC_MISALIGN_CHECK_EN
    misalign_next = 1'b0;
`endif

    case (state_reg)
      ST_BOOT: begin
        // All control inputs are ignored while booting.
        if (boot_cnt_reg == BOOT_LAST) begin
          state_next    = ST_RUN;
          boot_cnt_next = '0;
        end else begin
          boot_cnt_next = boot_cnt_reg + 4'd1;
        end
      end

      ST_RUN: begin
`ifdef PC_MISALIGN_CHECK_EN
        // A rejected redirect only matters if no valid trap pre-empted it.
        misalign_next = trap_bad || (redir_bad && !trap_ok);
`endif
        if (trap_ok) begin
          pc_next = trap_tgt;
        end else if (redir_ok) begin
          pc_next = redir_tgt;
        end else if (halt) begin
          // Halt wins over stall/increment; the PC freezes where it is.
          state_next = ST_HALT;
        end else if (!stall) begin
          pc_next = pc_reg + STEP_W;
        end
        // A taken trap/redirect defers halt by one edge: the new PC is
        // installed first and halt is re-evaluated next cycle.
      end

      ST_HALT: begin
        if (!halt) begin
          state_next = ST_RUN;
        end
      end

      default: begin
        state_next    = ST_BOOT;
        boot_cnt_next = '0;
        pc_next       = RESET_VECTOR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc           = pc_reg;
  assign pc_plus_step = pc_reg + STEP_W;
  assign pc_valid     = (state_reg == ST_RUN);
  assign halted       = (state_reg == ST_HALT);

`ifdef PC_MISALIGN_CHECK_EN
  assign misalign_err = misalign_reg;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC/address width in bits (min 8).
REQ-002 SHALL have parameter RESET_VECTOR, default 0, meaning first fetch address after boot.
REQ-003 SHALL have parameter BOOT_CYCLES, default 1, meaning post-reset clocks before fetch starts (1..15).
REQ-004 SHALL have parameter STEP, default 4, meaning sequential PC increment.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port stall  input  1  hold PC this cycle.
REQ-008 SHALL have port halt  input  1  request halt (debug/step).
REQ-009 SHALL have port redirect_valid  input  1  branch/jump taken.
REQ-010 SHALL have port redirect_target  input  WIDTH  branch/jump destination.
REQ-011 SHALL have port trap_valid  input  1  trap/exception entry.
REQ-012 SHALL have port trap_vector  input  WIDTH  trap handler address.
REQ-013 SHALL have port pc  output  WIDTH  current fetch address (registered).
REQ-014 SHALL have port pc_plus_step  output  WIDTH  pc + STEP, modulo 2^WIDTH (combinational from pc).
REQ-015 SHALL have port pc_valid  output  1  pc is a valid fetch address this cycle.
REQ-016 SHALL have port halted  output  1  unit is in HALT state.
REQ-017 SHALL have port misalign_err  output  1  one-cycle pulse, rejected misaligned redirect.

Function
REQ-018 SHALL implement states BOOT, RUN, HALT; reset enters BOOT.
REQ-019 BOOT SHALL hold pc = RESET_VECTOR, pc_valid = 0, count BOOT_CYCLES rising edges, then enter RUN; all other inputs ignored in BOOT.
REQ-020 RUN SHALL set pc_valid = 1 and update pc each edge by priority: trap_valid -> trap_vector; else redirect_valid -> redirect_target; else stall -> hold; else pc + STEP.
REQ-021 trap_valid and redirect_valid SHALL override stall in the same cycle.
REQ-022 Sequential increment SHALL wrap modulo 2^WIDTH (all-ones minus STEP+1 wraps to low addresses, no error).
REQ-023 RUN with halt = 1 and no trap/redirect SHALL enter HALT next edge, pc held; a simultaneous trap or redirect SHALL be applied first and HALT entered on the following edge if halt persists.
REQ-024 HALT SHALL hold pc, drive pc_valid = 0, halted = 1, ignore stall/redirect/trap; halt = 0 returns to RUN next edge with pc unchanged.
REQ-025 Latency from redirect/trap assertion to new pc SHALL be exactly one clock.
REQ-026 misalign_err SHALL be 0 except as defined in REQ-031.

Reset
REQ-027 rst_n low SHALL asynchronously force state = BOOT, boot counter = 0, pc = RESET_VECTOR, pc_valid = 0, halted = 0, misalign_err = 0.
REQ-028 Reset asserted mid-RUN or mid-HALT SHALL discard all pending redirect/trap/halt state; behaviour after release identical to power-on.
REQ-029 Release of rst_n SHALL take effect at the first rising edge after deassertion; BOOT count starts at that edge.

Configuration
REQ-030 Macro PC_MISALIGN_CHECK_EN SHALL select alignment checking on redirect_target and trap_vector.
REQ-031 With PC_MISALIGN_CHECK_EN defined: a trap or redirect whose target is not a multiple of STEP SHALL be rejected (pc takes the next lower-priority action per REQ-020) and misalign_err SHALL pulse high for the cycle after that edge.
REQ-032 Without PC_MISALIGN_CHECK_EN: targets SHALL be accepted with low log2(STEP) bits forced to 0; misalign_err SHALL be tied 0.

Verification
REQ-033 Reset then release, BOOT_CYCLES=3, RESET_VECTOR=0x100 -> pc=0x100, pc_valid=0 for 3 edges, then pc_valid=1, pc=0x100, 0x104, 0x108 on following edges.
REQ-034 RUN at pc=0x200, stall=1 and redirect_valid=1 target 0x400 same cycle -> next pc=0x400; stall alone next cycle -> pc stays 0x400.
REQ-035 trap_valid (vector 0x80) and redirect_valid (0x400) together at pc=0x10 -> next pc=0x80.
REQ-036 halt=1 at pc=0x20 -> halted=1, pc_valid=0, pc=0x20 held while redirect to 0x900 is driven; halt=0 -> RUN, pc=0x20 then 0x24.
REQ-037 WIDTH=8, pc=0xFC, no stall -> next pc=0x00, no error.
REQ-038 With PC_MISALIGN_CHECK_EN, redirect to 0x402 at pc=0x10 -> pc=0x14, misalign_err=1 one cycle; without macro -> pc=0x400, misalign_err=0.
